// File: rtl/line_matrix_pkg.sv
// Shared widths and source-code encoding for the line crosspoint matrix.
// A source code selects const 0, const 1, or physical input line (code - SRC_LINE0).
package line_matrix_pkg;

  localparam int SRC_ZERO  = 0;
  localparam int SRC_ONE   = 1;
  localparam int SRC_LINE0 = 2;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_LOAD = 1'b1
  } load_state_e;

  function automatic int sw_width(input int num_inputs);
    return $clog2(num_inputs + SRC_LINE0);
  endfunction

  function automatic int ow_width(input int num_outputs);
    return (num_outputs > 1) ? $clog2(num_outputs) : 1;
  endfunction

endpackage

// File: rtl/line_route_table.sv
// Staged (host-written) and active (last broadcast) route tables, with a
// write port, a staged-to-active copy port and a registered readback port.
module line_route_table
  import line_matrix_pkg::*;
#(
  parameter int NUM_OUTPUTS = 10,
  parameter int SW          = 4,
  parameter int OW          = 4
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          wr_en_i,
  input  logic [OW-1:0] wr_addr_i,
  input  logic [SW-1:0] wr_data_i,
  input  logic          cp_en_i,
  input  logic [OW-1:0] cp_addr_i,
  input  logic [OW-1:0] sel_addr_i,
  output logic [SW-1:0] stg_data_o,
  output logic [SW-1:0] act_data_o,
  input  logic [OW-1:0] rd_addr_i,
  output logic [SW-1:0] rd_data_o
);

  localparam logic [OW:0] NUM_OUT_L = NUM_OUTPUTS[OW:0];

  logic [SW-1:0] staged_q [NUM_OUTPUTS];
  logic [SW-1:0] active_q [NUM_OUTPUTS];
  logic [SW-1:0] rd_q;
  logic [SW-1:0] rd_d;

  assign stg_data_o = staged_q[sel_addr_i];
  assign act_data_o = active_q[sel_addr_i];
  assign rd_data_o  = rd_q;

  always_comb begin
    rd_d = '0;
    if ({1'b0, rd_addr_i} < NUM_OUT_L) rd_d = active_q[rd_addr_i];
  end

  // Writes only happen in IDLE and copies only in LOAD, so they never collide.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_OUTPUTS; i++) begin
        staged_q[i] <= SW'(SRC_ZERO);
        active_q[i] <= SW'(SRC_ZERO);
      end
      rd_q <= '0;
    end else begin
      if (wr_en_i) staged_q[wr_addr_i] <= wr_data_i;
      if (cp_en_i) active_q[cp_addr_i] <= staged_q[cp_addr_i];
      rd_q <= rd_d;
    end
  end

endmodule

// File: rtl/line_route_loader.sv
// Host-facing route loader: stages writes, then walks every output ID on
// commit, broadcasting (output_select, input_select) to all crosspoints.
module line_route_loader
  import line_matrix_pkg::*;
#(
  parameter  int NUM_INPUTS  = 10,
  parameter  int NUM_OUTPUTS = 10,
  localparam int SW          = sw_width(NUM_INPUTS),
  localparam int OW          = ow_width(NUM_OUTPUTS)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [OW-1:0] cfg_output,
  input  logic [SW-1:0] cfg_input,
  input  logic          commit,
  output logic          busy,
  output logic          done,
  output logic          err,
  input  logic          err_clr,
  output logic [OW-1:0] output_select,
  output logic [SW-1:0] input_select,
  input  logic [OW-1:0] rd_addr,
  output logic [SW-1:0] rd_data
);

  localparam int          MAX_SRC   = NUM_INPUTS + SRC_LINE0 - 1;
  localparam logic [SW:0] MAX_SRC_L = MAX_SRC[SW:0];
  localparam logic [OW:0] NUM_OUT_L = NUM_OUTPUTS[OW:0];
  localparam int          LAST_I    = NUM_OUTPUTS - 1;
  localparam logic [OW-1:0] K_LAST  = LAST_I[OW-1:0];
  localparam logic [OW-1:0] K_ONE   = {{(OW-1){1'b0}}, 1'b1};

  load_state_e   state_q, state_d;
  logic [OW-1:0] k_q, k_d;
  logic          pending_q, pending_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic          accept;
  logic          legal;
  logic          wr_en;
  logic [SW-1:0] stg_data;
  logic [SW-1:0] act_data;

  assign cfg_ready = (state_q == S_IDLE);
  assign busy      = (state_q == S_LOAD);
  assign done      = done_q;
  assign err       = err_q;

  assign accept = cfg_valid && cfg_ready;
  assign legal  = ({1'b0, cfg_output} < NUM_OUT_L) && ({1'b0, cfg_input} <= MAX_SRC_L);
  assign wr_en  = accept && legal;

  // k holds its final value in IDLE, so output_select keeps the last address
  // and the idle broadcast re-sends that entry's active value.
  assign output_select = k_q;
  assign input_select  = busy ? stg_data : act_data;

  line_route_table #(
    .NUM_OUTPUTS (NUM_OUTPUTS),
    .SW          (SW),
    .OW          (OW)
  ) u_table (
    .clk        (clk),
    .rstn       (rstn),
    .wr_en_i    (wr_en),
    .wr_addr_i  (cfg_output),
    .wr_data_i  (cfg_input),
    .cp_en_i    (busy),
    .cp_addr_i  (k_q),
    .sel_addr_i (k_q),
    .stg_data_o (stg_data),
    .act_data_o (act_data),
    .rd_addr_i  (rd_addr),
    .rd_data_o  (rd_data)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      k_q       <= '0;
      pending_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      pending_q <= pending_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    pending_d = pending_q;
    done_d    = 1'b0;
    // A dropped write wins over a same-cycle clear.
    err_d     = (accept && !legal) ? 1'b1 : (err_clr ? 1'b0 : err_q);
    case (state_q)
      S_IDLE: begin
        if (commit) begin
          state_d = S_LOAD;
          k_d     = '0;
        end
      end
      S_LOAD: begin
        if (k_q == K_LAST) begin
          done_d = 1'b1;
          if (pending_q || commit) begin
            k_d       = '0;
            pending_d = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          k_d = k_q + K_ONE;
          if (commit) pending_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_line_route_loader.sv
// Scoreboard bench for line_route_loader: stimulus queues expected broadcasts
// and done pulses (with cycle stamps); a negedge monitor pops and compares.
module tb_line_route_loader;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [3:0] cfg_output = '0;
  logic [3:0] cfg_input = '0;
  logic       commit = 1'b0;
  logic       busy, done, err;
  logic       err_clr = 1'b0;
  logic [3:0] output_select, input_select;
  logic [3:0] rd_addr = '0;
  logic [3:0] rd_data;

  typedef struct {
    int cyc;
    int os;
    int is;
  } bc_t;

  bc_t bc_q[$];
  int  done_q[$];
  int  mstg[10];
  int  cyc = 0;
  int  nchk = 0;
  int  nerr = 0;

  line_route_loader #(.NUM_INPUTS(10), .NUM_OUTPUTS(10)) dut (
    .clk(clk), .rstn(rstn), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_output(cfg_output), .cfg_input(cfg_input), .commit(commit),
    .busy(busy), .done(done), .err(err), .err_clr(err_clr),
    .output_select(output_select), .input_select(input_select),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every busy cycle must match the next queued broadcast, every
  // done pulse the next queued done cycle.
  always @(negedge clk) begin
    if (busy === 1'b1) begin
      if (bc_q.size() == 0) begin
        chk("bcast_unexpected", int'(output_select), -1);
      end else begin
        bc_t e;
        e = bc_q.pop_front();
        chk("bcast_cycle", cyc, e.cyc);
        chk("bcast_output_select", int'(output_select), e.os);
        chk("bcast_input_select", int'(input_select), e.is);
      end
    end
    if (done === 1'b1) begin
      if (done_q.size() == 0) chk("done_unexpected", cyc, -1);
      else chk("done_cycle", cyc, done_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int o, input int i, input bit clr);
    cfg_valid  = 1'b1;
    cfg_output = 4'(o);
    cfg_input  = 4'(i);
    err_clr    = clr;
    if (o < 10 && i <= 11) mstg[o] = i;
    tick();
    cfg_valid = 1'b0;
    err_clr   = 1'b0;
  endtask

  task automatic push_walk(input int start, input int n, input bit with_done);
    for (int k = 0; k < n; k++) bc_q.push_back('{start + k, k, mstg[k]});
    if (with_done) done_q.push_back(start + 10);
  endtask

  task automatic do_commit();
    commit = 1'b1;
    push_walk(cyc + 1, 10, 1'b1);
    tick();
    commit = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 60) begin
      tick();
      n++;
    end
    chk("walk_finished_in_budget", int'(n < 60), 1);
    tick();
  endtask

  task automatic rd_chk(input int a, input int exp);
    rd_addr = 4'(a);
    tick();
    chk($sformatf("rd_data[%0d]", a), int'(rd_data), exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int t;
    for (int i = 0; i < 10; i++) mstg[i] = 0;

    // Reset and idle
    repeat (3) tick();
    rstn = 1'b1;
    repeat (5) tick();
    chk("idle_output_select", int'(output_select), 0);
    chk("idle_input_select", int'(input_select), 0);
    chk("idle_busy", int'(busy), 0);
    chk("idle_err", int'(err), 0);
    chk("idle_cfg_ready", int'(cfg_ready), 1);
    for (int a = 0; a < 16; a++) rd_chk(a, 0);

    // Basic walk: out3 <- line 3 (code 5), out9 <- const 1
    wr(3, 5, 1'b0);
    wr(9, 1, 1'b0);
    do_commit();
    wait_idle();
    chk("post_walk_output_select", int'(output_select), 9);
    chk("post_walk_input_select", int'(input_select), 1);
    rd_chk(3, 5);
    rd_chk(9, 1);
    rd_chk(0, 0);

    // Illegal writes and err handling
    wr(12, 0, 1'b0);
    chk("err_bad_output", int'(err), 1);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("err_cleared", int'(err), 0);
    wr(3, 13, 1'b0);
    chk("err_bad_input", int'(err), 1);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("err_cleared2", int'(err), 0);
    wr(12, 2, 1'b1);
    chk("err_set_beats_clr", int'(err), 1);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    wr(5, 11, 1'b0);
    chk("err_legal_max_src", int'(err), 0);

    // Commit during LOAD at index 4, with a write rejected while busy
    do_commit();
    t = cyc - 1;
    repeat (4) tick();
    commit     = 1'b1;
    cfg_valid  = 1'b1;
    cfg_output = 4'd0;
    cfg_input  = 4'd7;
    chk("cfg_ready_in_load", int'(cfg_ready), 0);
    push_walk(t + 11, 10, 1'b1);
    tick();
    commit    = 1'b0;
    cfg_valid = 1'b0;
    wait_idle();
    chk("no_write_during_load_err", int'(err), 0);
    rd_chk(0, 0);
    rd_chk(5, 11);

    // Write in the same cycle as commit is included
    cfg_valid  = 1'b1;
    cfg_output = 4'd0;
    cfg_input  = 4'd11;
    mstg[0]    = 11;
    do_commit();
    cfg_valid = 1'b0;
    wait_idle();
    rd_chk(0, 11);

    // Reset at walk index 6 aborts with no done pulse
    commit = 1'b1;
    push_walk(cyc + 1, 7, 1'b0);
    tick();
    commit = 1'b0;
    repeat (6) tick();
    rstn = 1'b0;
    tick();
    chk("rst_busy", int'(busy), 0);
    chk("rst_output_select", int'(output_select), 0);
    chk("rst_input_select", int'(input_select), 0);
    chk("rst_done", int'(done), 0);
    rstn = 1'b1;
    for (int i = 0; i < 10; i++) mstg[i] = 0;
    tick();
    chk("rst_after_busy", int'(busy), 0);
    for (int a = 0; a < 10; a++) rd_chk(a, 0);

    repeat (3) tick();
    chk("bcast_queue_drained", bc_q.size(), 0);
    chk("done_queue_drained", done_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/line_route_loader.md
LINE_ROUTE_LOADER -- requirements
Module: line_route_loader

Interface
REQ-001 Parameter NUM_INPUTS, default 10: number of physical input lines per crosspoint.
REQ-002 Parameter NUM_OUTPUTS, default 10: number of crosspoint outputs (IDs 0..NUM_OUTPUTS-1).
REQ-003 Define SW = clog2(NUM_INPUTS+2) and OW = clog2(NUM_OUTPUTS).
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rstn  input  1  reset, synchronous, active-low.
REQ-006 cfg_valid  input  1  host route write request.
REQ-007 cfg_ready  output  1  write accepted when cfg_valid && cfg_ready.
REQ-008 cfg_output  input  OW  destination output ID of the write.
REQ-009 cfg_input  input  SW  source code: 0 = const 0, 1 = const 1, 2+n = input line n.
REQ-010 commit  input  1  single-cycle pulse; copies the staged table to the crosspoints.
REQ-011 busy  output  1  high while a load walk is in progress.
REQ-012 done  output  1  one-cycle pulse when a walk completes.
REQ-013 err  output  1  sticky flag: an illegal write was dropped.
REQ-014 err_clr  input  1  clears err.
REQ-015 output_select  output  OW  broadcast address to all crosspoints.
REQ-016 input_select  output  SW  broadcast source code to all crosspoints.
REQ-017 rd_addr  input  OW  readback address.
REQ-018 rd_data  output  SW  readback of the active entry at rd_addr.

Function
REQ-019 The block SHALL hold two tables of NUM_OUTPUTS entries x SW bits: staged (host-written) and active (last value broadcast).
REQ-020 State machine: IDLE and LOAD.
REQ-021 In IDLE, cfg_ready SHALL be 1. In LOAD, cfg_ready SHALL be 0.
REQ-022 An accepted write SHALL update staged[cfg_output] at that clock edge.
REQ-023 A write SHALL be dropped and err set if cfg_output >= NUM_OUTPUTS or cfg_input > NUM_INPUTS+1.
REQ-024 err_clr SHALL clear err, except that a same-cycle error SHALL take priority and leave err set.
REQ-025 commit in IDLE at cycle t SHALL move the state to LOAD at t+1 with the walk index k=0.
REQ-026 A write accepted in the same cycle as commit SHALL be included in that commit.
REQ-027 In LOAD cycle k, output_select SHALL equal k and input_select SHALL equal staged[k]; active[k] SHALL take staged[k]; k SHALL increment.
REQ-028 After k = NUM_OUTPUTS-1, the state SHALL return to IDLE. done SHALL be 1 for exactly one cycle, at t+NUM_OUTPUTS+1.
REQ-029 busy SHALL be 1 exactly during LOAD cycles.
REQ-030 commit during LOAD SHALL set a pending flag. When the current walk completes, a second walk SHALL start immediately: state stays LOAD, done still pulses, and pending clears.
REQ-031 In IDLE, output_select SHALL hold its last value, and input_select SHALL equal active[output_select]. Because crosspoints latch on address match alone, this keeps the idle broadcast idempotent.
REQ-032 rd_data SHALL equal active[rd_addr], registered with 1-cycle latency. An out-of-range rd_addr SHALL return 0.
REQ-033 Walk latency SHALL be exactly NUM_OUTPUTS cycles, with no bubbles.

Reset
REQ-034 While rstn=0 at a clock edge, the block SHALL set: state IDLE, k=0, staged and active all 0 (const 0), output_select=0, input_select=0, busy=0, done=0, err=0, pending=0, rd_data=0.
REQ-035 Reset during LOAD SHALL abort the walk with no done pulse. Crosspoints already loaded are cleared by their own reset.

Structure
REQ-036 Package line_matrix_pkg SHALL hold the SW/OW width functions and the source-code constants SRC_ZERO=0, SRC_ONE=1, SRC_LINE0=2.
REQ-037 The block SHALL use one sub-module, line_route_table: the staged and active register arrays with a write port, a copy port and a registered read port. The FSM, index counter and broadcast logic SHALL stay in line_route_loader.

Verification (NUM_INPUTS=10, NUM_OUTPUTS=10, SW=4, OW=4)
REQ-038 Reset, then idle 5 cycles -> output_select=0, input_select=0, busy=0, err=0, and rd_data=0 for every rd_addr.
REQ-039 Write out3<-5 (line 3) and out9<-1, then commit at cycle t -> busy high t+1..t+10; output_select 0..9 sequential; input_select=5 at index 3, 1 at index 9, 0 elsewhere; done at t+11; rd_addr=3 returns 5.
REQ-040 Write cfg_output=12, then cfg_input=13 -> both dropped, err=1, staged unchanged. err_clr -> err=0. err_clr in the same cycle as a bad write -> err stays 1.
REQ-041 commit at walk index 4, with a write rejected during LOAD (cfg_ready=0) -> first done, then an immediate second walk (busy continuous for 20 cycles) and a second done.
REQ-042 Write out0<-11 in the same cycle as commit -> LOAD index 0 broadcasts input_select=11.
REQ-043 rstn=0 at walk index 6 -> next cycle busy=0, output_select=0, no done pulse, and rd_data=0 for every rd_addr.
